// File: rtl/mem_arb_pkg.sv
// Shared types for the cache-line memory arbiter: FSM states, port ids and op codes.
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_e;
  typedef enum logic {MEM_OP_READ, MEM_OP_WRITE} mem_op_e;
  localparam logic ARB_PORT_I = 1'b0;
  localparam logic ARB_PORT_D = 1'b1;
endpackage

// File: rtl/mem_line_store.sv
// Single-port line-wide synchronous RAM with registered read (write returns the written line).
module mem_line_store #(
  parameter int W     = 128,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_q       <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter of I-cache and D-cache line traffic onto one fixed-latency line memory.
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int MEM_LATENCY     = 5,
  parameter int MEM_DEPTH_LINES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_icache_read_en,
  input  logic [31:0]                in_icache_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_icache_read_data,
  output logic                       out_icache_ready,
  input  logic                       in_dcache_read_en,
  input  logic                       in_dcache_write_en,
  input  logic [31:0]                in_dcache_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_dcache_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_dcache_read_data,
  output logic                       out_dcache_ready,
  output logic                       out_busy
);
  localparam int CLS = CACHE_LINE_SIZE;
  localparam int OFF = $clog2(CLS/8);
  localparam int IDX = $clog2(MEM_DEPTH_LINES);
  localparam int CW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  arb_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               lg_q, lg_d;
  logic               port_q, port_d;
  mem_op_e            op_q, op_d;
  logic [IDX-1:0]     idx_q, idx_d;
  logic [CLS-1:0]     wdata_q, wdata_d;
  logic [CLS-1:0]     ird_q, drd_q;
  logic [CLS-1:0]     ram_rdata;
  logic               mem_en, req_i, req_d, win;
  logic               resp_i, resp_d;

  // Address bits outside the line index are intentionally aliased away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{in_icache_addr[31:OFF+IDX], in_icache_addr[OFF-1:0],
                              in_dcache_addr[31:OFF+IDX], in_dcache_addr[OFF-1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lg_d    = lg_q;
    port_d  = port_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mem_en  = 1'b0;
    req_i   = in_icache_read_en;
    req_d   = in_dcache_read_en | in_dcache_write_en;
    win     = (req_i && req_d) ? ~lg_q : req_d;
    case (state_q)
      ARB_IDLE: begin
        if (req_i || req_d) begin
          port_d  = win;
          lg_d    = win;
          op_d    = (win == ARB_PORT_D && in_dcache_write_en) ? MEM_OP_WRITE : MEM_OP_READ;
          idx_d   = (win == ARB_PORT_D) ? in_dcache_addr[OFF+IDX-1:OFF]
                                        : in_icache_addr[OFF+IDX-1:OFF];
          wdata_d = in_dcache_write_data;
          cnt_d   = CW'(MEM_LATENCY - 1);
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          mem_en  = 1'b1;
          state_d = ARB_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      lg_q    <= ARB_PORT_I;
      port_q  <= ARB_PORT_I;
      op_q    <= MEM_OP_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      ird_q   <= '0;
      drd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lg_q    <= lg_d;
      port_q  <= port_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      if (resp_i) ird_q <= ram_rdata;
      if (resp_d) drd_q <= ram_rdata;
    end
  end

  mem_line_store #(.W(CLS), .DEPTH(MEM_DEPTH_LINES)) u_store (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (op_q == MEM_OP_WRITE),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // In RESP the RAM output register already holds the line; it is captured on leaving RESP.
  assign resp_i               = (state_q == ARB_RESP) && (port_q == ARB_PORT_I);
  assign resp_d               = (state_q == ARB_RESP) && (port_q == ARB_PORT_D);
  assign out_icache_ready     = resp_i;
  assign out_dcache_ready     = resp_d;
  assign out_icache_read_data = resp_i ? ram_rdata : ird_q;
  assign out_dcache_read_data = resp_d ? ram_rdata : drd_q;
  assign out_busy             = (state_q != ARB_IDLE);
endmodule

// File: tb/tb_mem_line_arbiter.sv
// Randomized and directed bench for mem_line_arbiter against a transaction-timeline model.
module tb_mem_line_arbiter;
  localparam int CLS = 128, L = 5, DEPTH = 1024, OFF = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_icache_read_en, in_dcache_read_en, in_dcache_write_en;
  logic [31:0]    in_icache_addr, in_dcache_addr;
  logic [CLS-1:0] in_dcache_write_data;
  logic [CLS-1:0] out_icache_read_data, out_dcache_read_data;
  logic           out_icache_ready, out_dcache_ready, out_busy;

  mem_line_arbiter #(.CACHE_LINE_SIZE(CLS), .MEM_LATENCY(L), .MEM_DEPTH_LINES(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_icache_read_en(in_icache_read_en), .in_icache_addr(in_icache_addr),
    .out_icache_read_data(out_icache_read_data), .out_icache_ready(out_icache_ready),
    .in_dcache_read_en(in_dcache_read_en), .in_dcache_write_en(in_dcache_write_en),
    .in_dcache_addr(in_dcache_addr), .in_dcache_write_data(in_dcache_write_data),
    .out_dcache_read_data(out_dcache_read_data), .out_dcache_ready(out_dcache_ready),
    .out_busy(out_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0, errors = 0;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string tag, input logic [CLS-1:0] obs, input logic [CLS-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Timeline model: one transaction in flight; ready L+1 cycles after the grant cycle,
  // arbiter free again the cycle after ready.
  logic [CLS-1:0] mmem [DEPTH];
  bit             mknown [DEPTH];
  bit             p_valid, p_side, p_we, lg;
  int             p_idx, p_grant, p_due, free_at;
  logic [CLS-1:0] p_data;
  logic [CLS-1:0] exp_rd [2];
  bit             exp_kn [2];
  bit             gq [$];

  initial begin
    for (int k = 0; k < DEPTH; k++) mknown[k] = 0;
    forever begin
      bit rdy [2];
      bit busy_e, ri, rd, s;
      @(negedge clk);
      if (!reset) begin
        p_valid = 0; lg = 0; free_at = 0;
        for (int k = 0; k < 2; k++) begin exp_rd[k] = '0; exp_kn[k] = 1; end
      end
      for (int k = 0; k < 2; k++) rdy[k] = p_valid && (p_due == cyc) && (p_side == k[0]);
      busy_e = p_valid && (cyc > p_grant) && (cyc <= p_due);
      if (rdy[0] || rdy[1]) begin
        if (p_we) begin
          mmem[p_idx] = p_data; mknown[p_idx] = 1;
          exp_rd[p_side] = p_data; exp_kn[p_side] = 1;
        end else begin
          exp_rd[p_side] = mmem[p_idx]; exp_kn[p_side] = mknown[p_idx];
        end
      end
      chk("i_ready", out_icache_ready, rdy[0]);
      chk("d_ready", out_dcache_ready, rdy[1]);
      chk("busy", out_busy, busy_e);
      if (exp_kn[0]) chk("i_data", out_icache_read_data, exp_rd[0]);
      if (exp_kn[1]) chk("d_data", out_dcache_read_data, exp_rd[1]);
      if (rdy[0] || rdy[1]) begin p_valid = 0; free_at = cyc + 1; end
      if (reset && !p_valid && cyc >= free_at) begin
        ri = in_icache_read_en;
        rd = in_dcache_read_en | in_dcache_write_en;
        if (ri || rd) begin
          s = (ri && rd) ? ~lg : rd;
          lg = s; p_side = s; p_valid = 1; p_grant = cyc; p_due = cyc + L + 1;
          p_we   = s && in_dcache_write_en;
          p_idx  = ((s ? in_dcache_addr : in_icache_addr) >> OFF) % DEPTH;
          p_data = in_dcache_write_data;
          gq.push_back(s);
        end
      end
    end
  end

  task automatic do_i(input logic [31:0] a, output int lat);
    int st; bit got;
    @(posedge clk); #1;
    in_icache_read_en = 1; in_icache_addr = a; st = cyc; got = 0;
    for (int k = 0; k < 100 && !got; k++) begin @(negedge clk); if (out_icache_ready) got = 1; end
    lat = cyc - st;
    chk("i_done", got, 1);
    @(posedge clk); #1;
    in_icache_read_en = 0;
  endtask

  task automatic do_d(input bit we, input bit re, input logic [31:0] a,
                      input logic [CLS-1:0] d, output int lat);
    int st; bit got;
    @(posedge clk); #1;
    in_dcache_write_en = we; in_dcache_read_en = re; in_dcache_addr = a;
    in_dcache_write_data = d; st = cyc; got = 0;
    for (int k = 0; k < 100 && !got; k++) begin @(negedge clk); if (out_dcache_ready) got = 1; end
    lat = cyc - st;
    chk("d_done", got, 1);
    @(posedge clk); #1;
    in_dcache_write_en = 0; in_dcache_read_en = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; reset = 0;
    @(posedge clk); #1; reset = 1;
  endtask

  initial begin
    logic [CLS-1:0] pa5, p2, p3;
    int li, ld;
    pa5 = {16{8'hA5}};
    p2  = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0, 32'hDEAD_BEEF};
    p3  = {4{32'h5A5A_0000}};
    reset = 0;
    in_icache_read_en = 1; in_dcache_read_en = 1; in_dcache_write_en = 0;
    in_icache_addr = '0; in_dcache_addr = '0; in_dcache_write_data = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1; in_icache_read_en = 0; in_dcache_read_en = 0;
    @(negedge clk); chk("rst_idle0", out_busy, 0);
    @(negedge clk); chk("rst_idle1", out_busy, 0);

    do_d(1, 0, 32'h40, pa5, ld); chk("wr_lat", ld, L + 1);
    do_d(0, 1, 32'h40, '0, ld);  chk("rd_lat", ld, L + 1);
    chk("rd_a5", out_dcache_read_data, pa5);
    chk("i_untouched", out_icache_read_data, '0);

    pulse_reset();
    fork
      do_d(0, 1, 32'h40, '0, ld);
      do_i(32'h40, li);
    join
    chk("both_d_lat", ld, L + 1);
    chk("both_i_lat", li, 2 * (L + 2) - 1);
    chk("both_i_data", out_icache_read_data, pa5);

    pulse_reset();
    gq.delete();
    fork
      begin int x; for (int k = 0; k < 3; k++) do_d(0, 1, 32'h40, '0, x); end
      begin int y; for (int k = 0; k < 3; k++) do_i(32'h40, y); end
    join
    chk("alt_n", gq.size(), 6);
    for (int k = 0; k < 6 && k < gq.size(); k++)
      chk($sformatf("alt%0d", k), gq[k], (k % 2 == 0));

    do_d(1, 0, 32'h10, p2, ld);
    do_d(0, 1, 32'h10 + DEPTH * CLS / 8, '0, ld);
    chk("alias", out_dcache_read_data, p2);

    @(posedge clk); #1;
    in_dcache_write_en = 1; in_dcache_addr = 32'h40; in_dcache_write_data = p3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0; in_dcache_write_en = 0;
    @(posedge clk); #1;
    reset = 1;
    do_d(0, 1, 32'h40, '0, ld);
    chk("rst_drop", out_dcache_read_data, pa5);
    do_i(32'h10, li);
    chk("resume", out_icache_read_data, p2);

    fork
      begin
        int x;
        for (int k = 0; k < 15; k++) begin
          bit w;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          w = $urandom_range(0, 1);
          do_d(w, w ? $urandom_range(0, 1) : 1'b1,
               ($urandom << 14) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15),
               {$urandom, $urandom, $urandom, $urandom}, x);
        end
      end
      begin
        int y;
        for (int k = 0; k < 15; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_i(($urandom << 14) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15), y);
        end
      end
    join

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
